matmul_sched: RTL and testbench
===============================

MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension; only 4 is verified.
REQ-002 SHALL have parameter DATA_W, default 8, operand element width (unsigned).
REQ-003 SHALL have parameter ACC_W, default 16, result element width (unsigned).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start_valid  input  1  requester offers a job.
REQ-007 SHALL have port start_ready  output  1  block can accept a job.
REQ-008 SHALL have port a  input  N*N*DATA_W  matrix A, row-major, element [i][j] at bits (i*N+j)*DATA_W.
REQ-009 SHALL have port b  input  N*N*DATA_W  matrix B, same packing as a.
REQ-010 SHALL have port res  output  N*N*ACC_W  result matrix C = A*B, same packing.
REQ-011 SHALL have port done_valid  output  1  res holds a complete result.
REQ-012 SHALL have port done_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port busy  output  1  high in RUN state.
REQ-014 SHALL have port overflow  output  1  sticky; some accumulation exceeded 2^ACC_W-1 in the current job.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 start_ready SHALL equal (state==IDLE); start_valid outside IDLE SHALL be ignored.
REQ-017 On an edge with start_valid && start_ready: capture a and b into internal registers, clear overflow, zero the 6-bit index {i,j,k}, go to RUN.
REQ-018 Captured operands SHALL be used for the whole job; changes on a/b after acceptance SHALL have no effect.
REQ-019 In RUN, exactly one MAC SHALL execute per cycle using the shared mac_pe: product = A[i][k]*B[k][j].
REQ-020 Index order SHALL be k fastest, then j, then i; the index SHALL increment by 1 each RUN cycle.
REQ-021 Accumulator: when k==0, acc_next = product; otherwise acc_next = acc + product; both truncated modulo 2^ACC_W.
REQ-022 On any carry out of ACC_W bits, overflow SHALL be set and held until the next acceptance or reset.
REQ-023 When k==N-1, res[i][j] SHALL be written with acc_next on that edge.
REQ-024 On the edge where the index equals N*N*N-1 (63), state SHALL go to DONE; done_valid SHALL be high exactly 64 cycles after the acceptance edge.
REQ-025 done_valid SHALL equal (state==DONE); on an edge with done_valid && done_ready, state SHALL go to IDLE.
REQ-026 A new job SHALL NOT be accepted in the same cycle as the done handshake; start_ready rises the following cycle.
REQ-027 res elements not yet written in the current job SHALL retain their previous values; res is defined only while done_valid is high.
REQ-028 While in DONE and in the following IDLE, res SHALL remain stable until the next job writes element [0][0].
REQ-029 busy SHALL equal (state==RUN).

Reset
REQ-030 When reset==0 at a clock edge: state=IDLE, index=0, acc=0, all res elements=0, overflow=0, operand registers=0.
REQ-031 Reset SHALL take priority over every handshake, including mid-RUN; an in-progress job SHALL be discarded with no done_valid.
REQ-032 Reset values of outputs: start_ready=1, done_valid=0, busy=0, overflow=0, res=0.

Structure
REQ-033 Shared package matmul_pkg SHALL hold N, DATA_W, ACC_W, the FSM state enum, and the index-width constant.
REQ-034 One sub-module, mac_pe, SHALL be purely combinational: inputs DATA_W a, DATA_W b, ACC_W acc, 1 clear; outputs ACC_W sum and 1 carry.
REQ-035 All sequencing, operand capture, and result storage SHALL reside in matmul_sched.

Verification
REQ-036 A=identity, B[i][j]=i*4+j -> after 64 RUN cycles res[i][j]=i*4+j, overflow=0.
REQ-037 A all 1, B all 2 -> every res element=8; done_valid rises exactly 64 cycles after acceptance.
REQ-038 A all 255, B all 255 -> every res element=63492 (260100 mod 65536), overflow=1.
REQ-039 start_valid held high through RUN and DONE, with done_ready low for 10 DONE cycles -> no second acceptance; done_valid and res remain stable; on the handshake go to IDLE, then accept on the next cycle.
REQ-040 reset driven low at RUN cycle 30 -> next edge shows IDLE, res all 0, busy=0, done_valid never asserts.
REQ-041 Change a and b on the cycle after acceptance -> result matches the originally captured operands.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and FSM state type for the 4x4 matrix-multiply scheduler.
package matmul_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LOG_N  = $clog2(N);
  // {i,j,k} packed into one counter, k in the low bits
  localparam int IDX_W  = 3 * LOG_N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mac_pe.sv
// Combinational multiply-accumulate element: sum = (clear ? 0 : acc) + a*b, with carry out of ACC_W bits.
module mac_pe #(
  parameter int DATA_W = matmul_pkg::DATA_W,
  parameter int ACC_W  = matmul_pkg::ACC_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  localparam int PROD_W = 2 * DATA_W;
  // Wide enough that neither the product nor the running sum loses bits before the carry test
  localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

  logic [PROD_W-1:0] product;
  logic [SUM_W-1:0]  addend;
  logic [SUM_W-1:0]  total;

  always_comb begin
    product = PROD_W'(a) * PROD_W'(b);
    addend  = clear ? '0 : SUM_W'(acc);
    total   = SUM_W'(product) + addend;
    sum     = total[ACC_W-1:0];
    carry   = |total[SUM_W-1:ACC_W];
  end

endmodule

// File: rtl/matmul_sched.sv
// Sequential C = A*B scheduler: one shared MAC per cycle, k fastest, then j, then i; 64 cycles per 4x4 job.
module matmul_sched #(
  parameter int N      = matmul_pkg::N,
  parameter int DATA_W = matmul_pkg::DATA_W,
  parameter int ACC_W  = matmul_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [N*N*DATA_W-1:0]   a,
  input  logic [N*N*DATA_W-1:0]   b,
  output logic [N*N*ACC_W-1:0]    res,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic                    busy,
  output logic                    overflow
);

  import matmul_pkg::*;

  localparam int FW = IDX_W / 3;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    overflow_q, overflow_d;
  logic [N*N*DATA_W-1:0]   a_q, a_d;
  logic [N*N*DATA_W-1:0]   b_q, b_d;
  logic [N*N*ACC_W-1:0]    res_q, res_d;

  logic [FW-1:0]           i_idx, j_idx, k_idx;
  logic [2*FW-1:0]         a_sel, b_sel, r_sel;
  logic [DATA_W-1:0]       a_elem, b_elem;
  logic [ACC_W-1:0]        mac_sum;
  logic                    mac_carry;
  logic                    k_first, k_last;

  assign {i_idx, j_idx, k_idx} = idx_q;
  assign a_sel   = {i_idx, k_idx};
  assign b_sel   = {k_idx, j_idx};
  assign r_sel   = {i_idx, j_idx};
  assign a_elem  = a_q[int'(a_sel)*DATA_W +: DATA_W];
  assign b_elem  = b_q[int'(b_sel)*DATA_W +: DATA_W];
  assign k_first = (k_idx == '0);
  assign k_last  = (k_idx == FW'(N-1));

  mac_pe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a     (a_elem),
    .b     (b_elem),
    .acc   (acc_q),
    .clear (k_first),
    .sum   (mac_sum),
    .carry (mac_carry)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    overflow_d = overflow_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d        = a;
          b_d        = b;
          overflow_d = 1'b0;
          idx_d      = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = mac_sum;
        if (mac_carry) begin
          overflow_d = 1'b1;
        end
        if (k_last) begin
          res_d[int'(r_sel)*ACC_W +: ACC_W] = mac_sum;
        end
        // Index wraps to zero naturally after the last MAC of the job
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign done_valid  = (state_q == ST_DONE);
  assign overflow    = overflow_q;
  assign res         = res_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Directed self-checking bench for matmul_sched with hand-computed result tables.
module tb_matmul_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start_valid = 1'b0;
  logic                 start_ready;
  logic [N*N*DW-1:0]    a = '0;
  logic [N*N*DW-1:0]    b = '0;
  logic [N*N*AW-1:0]    res;
  logic                 done_valid;
  logic                 done_ready = 1'b0;
  logic                 busy;
  logic                 overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matmul_sched #(
    .N      (N),
    .DATA_W (DW),
    .ACC_W  (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res         (res),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy),
    .overflow    (overflow)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*N*DW-1:0] fill(input int v);
    logic [N*N*DW-1:0] r;
    for (int e = 0; e < N*N; e++) r[e*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [N*N*DW-1:0] ident();
    logic [N*N*DW-1:0] r;
    for (int e = 0; e < N*N; e++) r[e*DW +: DW] = ((e / N) == (e % N)) ? DW'(1) : DW'(0);
    return r;
  endfunction

  function automatic logic [N*N*DW-1:0] seq();
    logic [N*N*DW-1:0] r;
    for (int e = 0; e < N*N; e++) r[e*DW +: DW] = DW'(e);
    return r;
  endfunction

  function automatic int res_el(input int e);
    return int'(res[e*AW +: AW]);
  endfunction

  task automatic check_res(input string tag, input int exp[N*N]);
    for (int e = 0; e < N*N; e++) check_eq($sformatf("%s_res%0d", tag, e), res_el(e), exp[e]);
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_done_valid"}, done_valid, 1);
    $display("job %s: done after %0d cycles, overflow=%0b", tag, cyc, overflow);
  endtask

  task automatic accept(input string tag, input logic [N*N*DW-1:0] av, input logic [N*N*DW-1:0] bv);
    a = av;
    b = bv;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
  endtask

  task automatic handshake(input string tag);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check_eq({tag, "_idle_ready"}, start_ready, 1);
    check_eq({tag, "_idle_done"}, done_valid, 0);
  endtask

  initial begin
    int cyc;
    int exp[N*N];
    int seen;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check_eq("rst_start_ready", start_ready, 1);
    check_eq("rst_done_valid", done_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_res_zero", (res == '0), 1);
    reset = 1'b1;
    tick();

    // A = identity, B = sequence: C must equal B
    accept("ident", ident(), seq());
    wait_done("ident", cyc);
    check_eq("ident_latency", cyc, 64);
    for (int e = 0; e < N*N; e++) exp[e] = e;
    check_res("ident", exp);
    check_eq("ident_overflow", overflow, 0);
    handshake("ident");
    check_eq("ident_res_hold", res_el(5), 5);

    // All ones times all twos: every element 8
    accept("ones", fill(1), fill(2));
    wait_done("ones", cyc);
    check_eq("ones_latency", cyc, 64);
    for (int e = 0; e < N*N; e++) exp[e] = 8;
    check_res("ones", exp);
    check_eq("ones_overflow", overflow, 0);
    handshake("ones");

    // Saturated operands: 4*65025 = 260100, mod 65536 = 63492, with overflow
    accept("max", fill(255), fill(255));
    wait_done("max", cyc);
    for (int e = 0; e < N*N; e++) exp[e] = 63492;
    check_res("max", exp);
    check_eq("max_overflow", overflow, 1);
    handshake("max");
    check_eq("max_overflow_sticky", overflow, 1);

    // Operands change right after acceptance; result must use captured A=ones, B=seq
    accept("capture", fill(1), seq());
    a = ident();
    b = fill(255);
    check_eq("capture_overflow_clr", overflow, 0);
    check_eq("capture_res_retained", res_el(0), 63492);
    wait_done("capture", cyc);
    for (int e = 0; e < N*N; e++) exp[e] = 24 + 4 * (e % N);
    check_res("capture", exp);
    check_eq("capture_overflow", overflow, 0);
    handshake("capture");

    // start_valid held throughout; done_ready withheld for 10 DONE cycles
    a = fill(1);
    b = fill(2);
    start_valid = 1'b1;
    tick();
    check_eq("hold_busy", busy, 1);
    wait_done("hold", cyc);
    check_eq("hold_latency", cyc, 64);
    for (int n = 0; n < 10; n++) begin
      tick();
      check_eq($sformatf("hold_dv%0d", n), done_valid, 1);
      check_eq($sformatf("hold_sr%0d", n), start_ready, 0);
    end
    for (int e = 0; e < N*N; e++) exp[e] = 8;
    check_res("hold", exp);
    a = fill(255);
    b = fill(255);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check_eq("hold_hs_ready", start_ready, 1);
    check_eq("hold_hs_busy", busy, 0);
    check_eq("hold_hs_done", done_valid, 0);
    check_eq("hold_hs_res", res_el(15), 8);
    tick();
    start_valid = 1'b0;
    check_eq("hold_reaccept_busy", busy, 1);
    check_eq("hold_reaccept_ready", start_ready, 0);

    // Reset at RUN cycle 30 of the re-accepted job discards it
    for (int n = 0; n < 29; n++) tick();
    check_eq("abort_busy_pre", busy, 1);
    check_eq("abort_overflow_pre", overflow, 1);
    reset = 1'b0;
    tick();
    check_eq("abort_ready", start_ready, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done_valid, 0);
    check_eq("abort_overflow", overflow, 0);
    check_eq("abort_res_zero", (res == '0), 1);
    reset = 1'b1;
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (done_valid) seen = 1;
    end
    check_eq("abort_no_done", seen, 0);
    check_eq("abort_idle_ready", start_ready, 1);
    $display("job abort: reset mid-run, idle for 80 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
